alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Push-button sequencer around an external ALU: load A, load B/op, wait EXEC_WAIT, capture, show.
// Optional step debounce filter enabled by defining ALU_SEQ_DEBOUNCE_EN.
module alu_seq_ctrl #(
    parameter int EXEC_WAIT       = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] sw,
    input  logic        step,
    input  logic        clr,
    input  logic [31:0] alu_out,
    input  logic [3:0]  alu_flags,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [31:0] data,
    output logic [3:0]  flags,
    output logic [1:0]  state,
    output logic        done,
    output logic [7:0]  op_cnt
);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        SHOW   = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(EXEC_WAIT - 1);

    state_t      state_q;
    logic [31:0] alu_a_q, alu_b_q, data_q;
    logic [3:0]  alu_op_q, flags_q;
    logic        done_q;
    logic [7:0]  op_cnt_q, wait_q;

    logic        sync1_q, sync2_q, prev_q, arm_q;
    logic [1:0]  vld_pipe_q;
    logic        step_lvl, step_evt;

    // arm_q only sets once a genuine low level has come through the
    // synchronizer, so a button held across reset release is not an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            arm_q      <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            sync1_q    <= step;
            sync2_q    <= sync1_q;
            prev_q     <= step_lvl;
            vld_pipe_q <= {vld_pipe_q[0], 1'b1};
            if (vld_pipe_q[1] && !sync2_q)
                arm_q <= 1'b1;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DBW-1:0] db_cnt_q;
    logic           filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            filt_q   <= 1'b0;
        end else if (sync2_q == filt_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
            filt_q   <= sync2_q;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + DBW'(1);
        end
    end

    assign step_lvl = filt_q;
`else
    assign step_lvl = sync2_q;
`endif

    assign step_evt = step_lvl & ~prev_q & arm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_A;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            data_q   <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            op_cnt_q <= '0;
            wait_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (clr) begin
                state_q  <= WAIT_A;
                alu_a_q  <= '0;
                alu_b_q  <= '0;
                alu_op_q <= '0;
            end else begin
                case (state_q)
                    WAIT_A: if (step_evt) begin
                        alu_a_q <= sw;
                        state_q <= WAIT_B;
                    end
                    WAIT_B: if (step_evt) begin
                        alu_b_q  <= sw;
                        alu_op_q <= sw[3:0];
                        wait_q   <= '0;
                        state_q  <= EXEC;
                    end
                    // step events are simply not looked at here
                    EXEC: if (wait_q == WAIT_LAST) begin
                        data_q   <= alu_out;
                        flags_q  <= alu_flags;
                        done_q   <= 1'b1;
                        op_cnt_q <= op_cnt_q + 8'd1;
                        state_q  <= SHOW;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                    SHOW: if (step_evt) state_q <= WAIT_A;
                    default: state_q <= WAIT_A;
                endcase
            end
        end
    end

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
    assign data   = data_q;
    assign flags  = flags_q;
    assign state  = state_q;
    assign done   = done_q;
    assign op_cnt = op_cnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with an adder ALU model; debounce checks when ALU_SEQ_DEBOUNCE_EN is defined.
module tb_alu_seq_ctrl;

    localparam int EXEC_WAIT = 20;
    localparam int DB        = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif

    logic        clk, rst_n, step, clr;
    logic [31:0] sw, alu_out, alu_a, alu_b, data;
    logic [3:0]  alu_flags, alu_op, flags;
    logic [1:0]  state;
    logic        done;
    logic [7:0]  op_cnt;
    logic [32:0] sum;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;
    int done_seen = 0;

    alu_seq_ctrl #(.EXEC_WAIT(EXEC_WAIT), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .step(step), .clr(clr),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .data(data), .flags(flags), .state(state), .done(done), .op_cnt(op_cnt)
    );

    // adder ALU: flags {ZF,CF,OF,SF}, OF unused
    assign sum       = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_out   = sum[31:0];
    assign alu_flags = {sum[31:0] == 32'd0, sum[32], 1'b0, sum[31]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (rst_n && done === 1'b1) done_seen++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_a"}, alu_a, 32'd0);
        chk({tag, "_b"}, alu_b, 32'd0);
        chk({tag, "_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_data"}, data, 32'd0);
        chk({tag, "_flags"}, 32'(flags), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_opcnt"}, 32'(op_cnt), 32'd0);
    endtask

    task automatic press();
        step = 1'b1;
        repeat (LAT) tick();
    endtask

    task automatic release_step();
        step = 1'b0;
        repeat (LAT + 3) tick();
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        sw = a; press(); release_step();
        sw = b; press(); release_step();
        repeat (EXEC_WAIT) tick();
        press(); release_step();
    endtask

    initial begin
        rst_n = 1'b0; step = 1'b0; clr = 1'b0; sw = '0;
        #2;
        chk_zero("reset_init");
        rst_n = 1'b1;
        repeat (5) tick();

        // step latency and held button
        sw = 32'h5;
        step = 1'b1;
        repeat (LAT - 1) tick();
        chk("lat_early", 32'(state), 32'd0);
        tick();
        chk("lat_edge", 32'(state), 32'd1);
        chk("load_a", alu_a, 32'h5);
        sw = 32'h3;
        repeat (100 - LAT) tick();
        chk("held_state", 32'(state), 32'd1);
        chk("held_a", alu_a, 32'h5);
        release_step();

        // basic op 5 + 3
        press();
        chk("enter_exec", 32'(state), 32'd2);
        chk("load_b", alu_b, 32'h3);
        chk("load_op", 32'(alu_op), 32'd3);
        step = 1'b0;
        repeat (EXEC_WAIT - 1) tick();
        chk("exec_len", 32'(state), 32'd2);
        chk("exec_nodone", 32'(done), 32'd0);
        tick();
        chk("show_state", 32'(state), 32'd3);
        chk("cap_data", data, 32'h8);
        chk("cap_flags", 32'(flags), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        chk("opcnt1", 32'(op_cnt), 32'd1);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        repeat (LAT + 2) tick();
        chk("done_count1", 32'(done_seen), 32'd1);
        sw = 32'h77;
        press();
        chk("show_to_a", 32'(state), 32'd0);
        chk("show_hold_data", data, 32'h8);
        release_step();

        // step ignored in EXEC, then abort with clr
        sw = 32'h10; press(); release_step();
        sw = 32'h20; press();
        chk("abort_exec", 32'(state), 32'd2);
        step = 1'b0;
        repeat (LAT + 1) tick();
        step = 1'b1;
        repeat (LAT) tick();
        chk("exec_step_ignored", 32'(state), 32'd2);
        chk("exec_a_stable", alu_a, 32'h10);
        chk("exec_b_stable", alu_b, 32'h20);
        chk("exec_op_stable", 32'(alu_op), 32'd0);
        step = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_a", alu_a, 32'd0);
        chk("clr_b", alu_b, 32'd0);
        chk("clr_data", data, 32'h8);
        chk("clr_opcnt", 32'(op_cnt), 32'd1);
        repeat (EXEC_WAIT + 5) tick();
        chk("clr_nodone", 32'(done_seen), 32'd1);
        chk("clr_idle", 32'(state), 32'd0);

        // op_cnt wrap
        for (int i = 0; i < 254; i++) run_op(32'(i), 32'd1);
        chk("opcnt255", 32'(op_cnt), 32'd255);
        chk("data_254", data, 32'hFE);
        run_op(32'hFFFF_FFFF, 32'd1);
        chk("opcnt_wrap", 32'(op_cnt), 32'd0);
        chk("done_count256", 32'(done_seen), 32'd256);
        chk("wrap_data", data, 32'd0);
        chk("wrap_flags", 32'(flags), 32'hC);
        chk("wrap_state", 32'(state), 32'd0);

        // reset mid-EXEC, button held across release
        sw = 32'h1; press(); release_step();
        sw = 32'h2; press();
        chk("rst_pre_exec", 32'(state), 32'd2);
        rst_n = 1'b0;
        #2;
        chk_zero("reset_exec");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("held_over_reset", 32'(state), 32'd0);
        chk("held_over_reset_a", alu_a, 32'd0);
        release_step();
        sw = 32'hAB;
        press();
        chk("rearm_state", 32'(state), 32'd1);
        chk("rearm_a", alu_a, 32'hAB);
        release_step();
        chk("rst_done_count", 32'(done_seen), 32'd256);

`ifdef ALU_SEQ_DEBOUNCE_EN
        step = 1'b1;
        repeat (3) tick();
        step = 1'b0;
        repeat (10) tick();
        chk("db_glitch", 32'(state), 32'd1);
        step = 1'b1;
        repeat (6) tick();
        chk("db_press_early", 32'(state), 32'd1);
        step = 1'b0;
        tick();
        chk("db_press", 32'(state), 32'd2);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
